// File: rtl/juez_tablero.sv
// juez_tablero: referee for the tic-tac-toe board written by the square selector.
// It synchronises the nine cells and accepts or rejects each board change.
// An accepted move triggers a one-line-per-cycle win scan, then a draw check
// or a hand-over of the turn.
module juez_tablero #(
    parameter int N_SYNC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reiniciar,
    input  logic [1:0] guarda_c1,
    input  logic [1:0] guarda_c2,
    input  logic [1:0] guarda_c3,
    input  logic [1:0] guarda_c4,
    input  logic [1:0] guarda_c5,
    input  logic [1:0] guarda_c6,
    input  logic [1:0] guarda_c7,
    input  logic [1:0] guarda_c8,
    input  logic [1:0] guarda_c9,
    output logic       turno_p1,
    output logic       turno_p2,
    output logic       gana_p1,
    output logic       gana_p2,
    output logic       empate,
    output logic       juego_fin,
    output logic [3:0] linea_ganadora,
    output logic       jugada_invalida,
    output logic [3:0] num_jugadas
);

    typedef enum logic [2:0] {ESPERA, VALIDA, ESCANEO, DECIDE, FIN} estado_t;

    localparam logic [1:0] C_X = 2'b11;
    localparam logic [1:0] C_O = 2'b01;

    estado_t     estado, estado_n;
    logic [17:0] crudo;
    logic [17:0] sync_q [N_SYNC];
    logic [17:0] sync_prev;
    logic [17:0] tablero;
    logic [17:0] snapshot;
    logic [2:0]  k;

    // cell i (0..8) lives in bits [2i+1:2i]
    assign crudo = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                    guarda_c4, guarda_c3, guarda_c2, guarda_c1};

    // code 10 is just another spelling of empty
    function automatic logic [17:0] norm(input logic [17:0] b);
        logic [17:0] r;
        r = b;
        for (int i = 0; i < 9; i++)
            if (b[2*i +: 2] == 2'b10) r[2*i +: 2] = 2'b00;
        return r;
    endfunction

    // the three cell indices of line k, in linea_ganadora order
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    return {4'd0, 4'd1, 4'd2};
            3'd1:    return {4'd3, 4'd4, 4'd5};
            3'd2:    return {4'd6, 4'd7, 4'd8};
            3'd3:    return {4'd0, 4'd3, 4'd6};
            3'd4:    return {4'd1, 4'd4, 4'd7};
            3'd5:    return {4'd2, 4'd5, 4'd8};
            3'd6:    return {4'd0, 4'd4, 4'd8};
            default: return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // synchroniser chain plus a one-cycle-delayed copy for the skew filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SYNC; i++) sync_q[i] <= '0;
            sync_prev <= '0;
            tablero   <= '0;
        end else begin
            sync_q[0] <= crudo;
            for (int i = 1; i < N_SYNC; i++) sync_q[i] <= sync_q[i-1];
            sync_prev <= sync_q[N_SYNC-1];
            // only accept a board that held still for two cycles
            if (sync_q[N_SYNC-1] == sync_prev) tablero <= norm(sync_q[N_SYNC-1]);
        end
    end

    // move legality: exactly one changed cell, previously empty, right player's code
    logic [8:0] dif;
    logic       un_cambio;
    logic [1:0] viejo, nuevo;
    logic       legal;

    always_comb begin
        dif   = '0;
        viejo = 2'b00;
        nuevo = 2'b00;
        for (int i = 0; i < 9; i++) begin
            dif[i] = (tablero[2*i +: 2] != snapshot[2*i +: 2]);
            if (dif[i]) begin
                viejo = snapshot[2*i +: 2];
                nuevo = tablero[2*i +: 2];
            end
        end
        un_cambio = (dif != 9'd0) && ((dif & (dif - 9'd1)) == 9'd0);
        legal     = un_cambio && (viejo == 2'b00) &&
                    ((turno_p1 && nuevo == C_X) || (turno_p2 && nuevo == C_O));
    end

    // current scan line, read from the accepted snapshot so later edits cannot disturb it
    logic [11:0] lc;
    logic [1:0]  ca, cb, cc;
    logic        linea_ok;

    always_comb begin
        lc       = line_cells(k);
        ca       = snapshot[2*int'(lc[11:8]) +: 2];
        cb       = snapshot[2*int'(lc[7:4])  +: 2];
        cc       = snapshot[2*int'(lc[3:0])  +: 2];
        linea_ok = (ca == cb) && (cb == cc) && (ca != 2'b00);
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) estado <= ESPERA;
        else       estado <= estado_n;
    end

    logic do_snap, do_inv, do_inc, do_win, do_draw, do_toggle, k_inc;

    // next state and datapath strobes; reiniciar overrides everything
    always_comb begin
        estado_n  = estado;
        do_snap   = 1'b0;
        do_inv    = 1'b0;
        do_inc    = 1'b0;
        do_win    = 1'b0;
        do_draw   = 1'b0;
        do_toggle = 1'b0;
        k_inc     = 1'b0;
        if (reiniciar) begin
            estado_n = ESPERA;
        end else begin
            case (estado)
                ESPERA:
                    if (!juego_fin && tablero != snapshot) estado_n = VALIDA;
                VALIDA: begin
                    do_snap = 1'b1;
                    if (legal) begin
                        do_inc   = 1'b1;
                        estado_n = ESCANEO;
                    end else begin
                        do_inv   = 1'b1;
                        estado_n = ESPERA;
                    end
                end
                ESCANEO:
                    if (linea_ok) begin
                        do_win   = 1'b1;
                        estado_n = FIN;
                    end else if (k == 3'd7) begin
                        estado_n = DECIDE;
                    end else begin
                        k_inc = 1'b1;
                    end
                DECIDE:
                    if (num_jugadas == 4'd9) begin
                        do_draw  = 1'b1;
                        estado_n = FIN;
                    end else begin
                        do_toggle = 1'b1;
                        estado_n  = ESPERA;
                    end
                default: estado_n = FIN;
            endcase
        end
    end

    // game state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snapshot        <= '0;
            k               <= '0;
            turno_p1        <= 1'b1;
            turno_p2        <= 1'b0;
            gana_p1         <= 1'b0;
            gana_p2         <= 1'b0;
            empate          <= 1'b0;
            linea_ganadora  <= '0;
            jugada_invalida <= 1'b0;
            num_jugadas     <= '0;
        end else if (reiniciar) begin
            snapshot        <= '0;
            k               <= '0;
            turno_p1        <= 1'b1;
            turno_p2        <= 1'b0;
            gana_p1         <= 1'b0;
            gana_p2         <= 1'b0;
            empate          <= 1'b0;
            linea_ganadora  <= '0;
            jugada_invalida <= 1'b0;
            num_jugadas     <= '0;
        end else begin
            jugada_invalida <= do_inv;
            if (do_snap) snapshot <= tablero;
            if (do_inc) begin
                k <= '0;
                if (num_jugadas != 4'd9) num_jugadas <= num_jugadas + 4'd1;
            end
            if (k_inc) k <= k + 3'd1;
            if (do_win) begin
                linea_ganadora <= {1'b0, k} + 4'd1;
                gana_p1        <= (ca == C_X);
                gana_p2        <= (ca == C_O);
                turno_p1       <= 1'b0;
                turno_p2       <= 1'b0;
            end
            if (do_draw) begin
                empate   <= 1'b1;
                turno_p1 <= 1'b0;
                turno_p2 <= 1'b0;
            end
            if (do_toggle) begin
                turno_p1 <= ~turno_p1;
                turno_p2 <= ~turno_p2;
            end
        end
    end

    assign juego_fin = gana_p1 | gana_p2 | empate;

endmodule

// File: tb/tb_juez_tablero.sv
// Directed bench for juez_tablero: legal play, wins, draw, rejected moves, restarts.
module tb_juez_tablero;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       reiniciar = 1'b0;
    logic [1:0] c [9];
    logic       turno_p1, turno_p2, gana_p1, gana_p2, empate, juego_fin;
    logic       jugada_invalida;
    logic [3:0] linea_ganadora, num_jugadas;

    int total = 0;
    int bad = 0;
    int inv_cnt = 0;

    localparam logic [1:0] X = 2'b11;
    localparam logic [1:0] O = 2'b01;

    juez_tablero #(.N_SYNC(2)) dut (
        .clk(clk), .reset(reset), .reiniciar(reiniciar),
        .guarda_c1(c[0]), .guarda_c2(c[1]), .guarda_c3(c[2]),
        .guarda_c4(c[3]), .guarda_c5(c[4]), .guarda_c6(c[5]),
        .guarda_c7(c[6]), .guarda_c8(c[7]), .guarda_c9(c[8]),
        .turno_p1(turno_p1), .turno_p2(turno_p2),
        .gana_p1(gana_p1), .gana_p2(gana_p2), .empate(empate),
        .juego_fin(juego_fin), .linea_ganadora(linea_ganadora),
        .jugada_invalida(jugada_invalida), .num_jugadas(num_jugadas)
    );

    always #5 clk = ~clk;

    // count high cycles of the reject pulse
    always @(posedge clk) if (jugada_invalida) inv_cnt <= inv_cnt + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // write one cell and give the referee time to finish a full scan
    task automatic mv(input int idx, input logic [1:0] code);
        c[idx] = code;
        cyc(25);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 9; i++) c[i] = 2'b00;
    endtask

    task automatic restart();
        clear_board();
        reiniciar = 1'b1;
        cyc(8);
        reiniciar = 1'b0;
        cyc(2);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_t1"}, int'(turno_p1), 1);
        chk({tag, "_t2"}, int'(turno_p2), 0);
        chk({tag, "_num"}, int'(num_jugadas), 0);
        chk({tag, "_fin"}, int'(juego_fin), 0);
        chk({tag, "_lin"}, int'(linea_ganadora), 0);
    endtask

    int base;

    initial begin
        clear_board();
        cyc(3);
        reset = 1'b0;
        cyc(2);
        chk_reset_vals("rst");
        chk("rst_inv", int'(jugada_invalida), 0);

        // first move X at c5; turn must not flip mid-scan
        c[4] = X;
        cyc(10);
        chk("x5_hold_t1", int'(turno_p1), 1);
        cyc(15);
        chk("x5_t2", int'(turno_p2), 1);
        chk("x5_t1", int'(turno_p1), 0);
        chk("x5_num", int'(num_jugadas), 1);
        chk("x5_inv", inv_cnt, 0);

        // reiniciar in the middle of O's scan
        c[0] = O;
        cyc(8);
        clear_board();
        reiniciar = 1'b1;
        cyc(1);
        chk_reset_vals("rein");
        cyc(7);
        reiniciar = 1'b0;
        cyc(25);
        chk("rein_after_num", int'(num_jugadas), 0);
        chk("rein_after_t1", int'(turno_p1), 1);
        chk("rein_after_inv", inv_cnt, 0);

        // row 123 win by X
        mv(0, X); mv(3, O); mv(1, X); mv(4, O); mv(2, X);
        chk("row_g1", int'(gana_p1), 1);
        chk("row_g2", int'(gana_p2), 0);
        chk("row_lin", int'(linea_ganadora), 1);
        chk("row_fin", int'(juego_fin), 1);
        chk("row_t1", int'(turno_p1), 0);
        chk("row_t2", int'(turno_p2), 0);
        chk("row_num", int'(num_jugadas), 5);
        // board edits after the game ends are ignored
        mv(8, O);
        chk("fin_inv", inv_cnt, 0);
        chk("fin_num", int'(num_jugadas), 5);
        restart();
        chk_reset_vals("restart1");

        // wrong player's code
        base = inv_cnt;
        mv(8, O);
        chk("wrong_pl_inv", inv_cnt - base, 1);
        chk("wrong_pl_t1", int'(turno_p1), 1);
        chk("wrong_pl_num", int'(num_jugadas), 0);
        // overwrite an occupied cell
        mv(4, X);
        chk("x5b_num", int'(num_jugadas), 1);
        base = inv_cnt;
        mv(4, O);
        chk("overwr_inv", inv_cnt - base, 1);
        chk("overwr_t2", int'(turno_p2), 1);
        // two cells changed together
        base = inv_cnt;
        c[1] = O;
        c[2] = O;
        cyc(25);
        chk("double_inv", inv_cnt - base, 1);
        chk("double_num", int'(num_jugadas), 1);
        chk("double_t2", int'(turno_p2), 1);
        restart();

        // draw: X1 O2 X3 O5 X4 O6 X8 O7 X9
        mv(0, X); mv(1, O); mv(2, X); mv(4, O); mv(3, X);
        mv(5, O); mv(7, X); mv(6, O); mv(8, X);
        chk("draw_emp", int'(empate), 1);
        chk("draw_lin", int'(linea_ganadora), 0);
        chk("draw_num", int'(num_jugadas), 9);
        chk("draw_fin", int'(juego_fin), 1);
        chk("draw_g1", int'(gana_p1), 0);
        chk("draw_t1", int'(turno_p1), 0);
        restart();

        // diagonal 357 by O: X1 O3 X2 O5 X9 O7
        mv(0, X); mv(2, O); mv(1, X); mv(4, O); mv(8, X); mv(6, O);
        chk("diag_g2", int'(gana_p2), 1);
        chk("diag_g1", int'(gana_p1), 0);
        chk("diag_lin", int'(linea_ganadora), 8);
        chk("diag_num", int'(num_jugadas), 6);
        chk("diag_t2", int'(turno_p2), 0);
        restart();

        // asynchronous reset in the middle of a scan
        mv(4, X);
        chk("ar_pre_num", int'(num_jugadas), 1);
        c[0] = O;
        cyc(8);
        #2;
        reset = 1'b1;
        clear_board();
        #1;
        chk_reset_vals("areset");
        cyc(3);
        reset = 1'b0;
        cyc(25);
        chk("areset_after_num", int'(num_jugadas), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
